button_debounce: RTL



---
 rtl/btn_pkg.sv | 16 +
 rtl/sample_tick.sv | 30 +++
 rtl/button_debounce.sv | 134 +++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and width helpers for the push-button debounce block.
package btn_pkg;

  // Button FSM: released, pressed with hold timer running, pressed and auto-repeating.
  typedef enum logic [1:0] {
    StReleased      = 2'd0,
    StPressedWait   = 2'd1,
    StPressedRepeat = 2'd2
  } btn_fsm_e;

  // Bits needed to hold any value 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sample_tick.sv
// Single-cycle enable generator: tick is high for one clk_in cycle out of every DIV.
module sample_tick
  import btn_pkg::*;
#(
  parameter int unsigned DIV = 27_000
) (
  input  logic clk_in,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Free-running 0..DIV-1 counter, restarted by reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/button_debounce.sv
// Debounces an active-low push-button pin and emits press, release and auto-repeat strobes.
module button_debounce
  import btn_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV     = 27_000,
  parameter int unsigned STABLE_SAMPLES = 20,
  parameter int unsigned HOLD_SAMPLES   = 500,
  parameter int unsigned REPEAT_SAMPLES = 100,
  parameter bit          REPEAT_EN      = 1'b1
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_n,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DebW    = cnt_width(STABLE_SAMPLES);
  localparam int unsigned HoldMax = (HOLD_SAMPLES > REPEAT_SAMPLES) ? HOLD_SAMPLES
                                                                    : REPEAT_SAMPLES;
  localparam int unsigned HoldW   = cnt_width(HoldMax);

  localparam logic [DebW-1:0]  StableVal = DebW'(STABLE_SAMPLES);
  localparam logic [HoldW-1:0] HoldVal   = HoldW'(HOLD_SAMPLES);
  localparam logic [HoldW-1:0] RepeatVal = HoldW'(REPEAT_SAMPLES);

  logic             sync1_q, sync2_q;
  logic             sync_lvl;
  logic             tick;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_inc;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_inc;
  logic             mismatch, accept;
  btn_fsm_e         state_q;
  logic             btn_state_q, press_q, release_q, repeat_q;

  // Two-flop synchronizer, preset to "released" so reset can never fake a press.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  assign sync_lvl = ~sync2_q;

  sample_tick #(
    .DIV (SAMPLE_DIV)
  ) u_sample_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .tick   (tick)
  );

  assign deb_cnt_inc  = deb_cnt_q + DebW'(1);
  assign hold_cnt_inc = hold_cnt_q + HoldW'(1);
  assign mismatch     = (sync_lvl != btn_state_q);
  // A new level is accepted on the tick that completes the run of differing samples.
  assign accept       = tick && mismatch && (deb_cnt_inc == StableVal);

  // Debounce counter, button FSM, hold/repeat timer and registered strobes.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      state_q     <= StReleased;
      btn_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      if (tick) begin
        if (!mismatch || accept) begin
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_inc;
        end

        // An accepted level change outranks a hold/repeat expiry on the same tick.
        if (accept) begin
          btn_state_q <= sync_lvl;
          hold_cnt_q  <= '0;
          if (sync_lvl) begin
            state_q <= StPressedWait;
            press_q <= 1'b1;
          end else begin
            state_q   <= StReleased;
            release_q <= 1'b1;
          end
        end else begin
          case (state_q)
            StReleased: begin
              hold_cnt_q <= '0;
            end
            StPressedWait: begin
              if (hold_cnt_inc == HoldVal) begin
                hold_cnt_q <= '0;
                repeat_q   <= REPEAT_EN;
                state_q    <= StPressedRepeat;
              end else begin
                hold_cnt_q <= hold_cnt_inc;
              end
            end
            StPressedRepeat: begin
              if (hold_cnt_inc == RepeatVal) begin
                hold_cnt_q <= '0;
                repeat_q   <= REPEAT_EN;
              end else begin
                hold_cnt_q <= hold_cnt_inc;
              end
            end
            default: begin
              hold_cnt_q <= '0;
              state_q    <= StReleased;
            end
          endcase
        end
      end
    end
  end

  assign btn_state     = btn_state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule
